vga_timing_decoder: RTL and testbench



---
 rtl/vga_timing_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers x/y from hsync/hblnk/vsync/vblnk,
// measures line/frame geometry and reports lock once timing is consistent.
//
// state  | meaning
// S_IDLE | no frame start seen since reset
// S_HUNT | counting consecutive consistent frames
// S_LOCK | timing stable, violations pulse err
module vga_timing_decoder #(
   parameter int CW          = 11,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hsync,
   input  logic          hblnk,
   input  logic          vsync,
   input  logic          vblnk,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          pixel_valid,
   output logic          line_start,
   output logic          frame_start,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] v_total,
   output logic [CW-1:0] v_active,
   output logic          locked,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCK} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_lock_cnt;
   logic [3:0]    w_cnt_nxt;
   logic [3:0]    w_cnt_inc;

   logic          r_hblnk_q;
   logic          r_vblnk_q;
   logic          r_hsync_q;
   logic          r_vsync_q;
   logic [CW-1:0] r_hcnt;
   logic [CW-1:0] r_vcnt;
   logic          r_pend_v;
   logic          r_seen_ls;
   logic          r_ht_valid;
   logic          r_vt_valid;
   logic          r_in_active;
   logic [1:0]    r_hs_rise;
   logic [1:0]    r_hb_rise;
   logic [1:0]    r_vs_rise;
   logic          r_frame_bad;

   logic          r_pixel_valid;
   logic          r_line_start;
   logic          r_frame_start;
   logic [CW-1:0] r_h_total;
   logic [CW-1:0] r_h_active;
   logic [CW-1:0] r_v_total;
   logic [CW-1:0] r_v_active;
   logic          r_err;

   logic          w_ls;
   logic          w_fs;
   logic          w_hb_rise;
   logic          w_hs_rise;
   logic          w_vs_rise;
   logic          w_vb_fall;
   logic          w_hcnt_max;
   logic          w_vcnt_max;
   logic [CW-1:0] w_hcnt_inc;
   logic [CW-1:0] w_vcnt_inc;
   logic [2:0]    w_hs_tot;
   logic [2:0]    w_hb_tot;
   logic [2:0]    w_vs_tot;
   logic          w_line_fail;
   logic          w_frame_fail;
   logic          w_sat_fail;
   logic          w_fail;

   assign w_ls       = ~hblnk & r_hblnk_q;
   assign w_hb_rise  = hblnk & ~r_hblnk_q;
   assign w_hs_rise  = hsync & ~r_hsync_q;
   assign w_vs_rise  = vsync & ~r_vsync_q;
   assign w_vb_fall  = ~vblnk & r_vblnk_q;
   assign w_fs       = w_ls & (r_pend_v | w_vb_fall);

   assign w_hcnt_max = &r_hcnt;
   assign w_vcnt_max = &r_vcnt;
   assign w_hcnt_inc = w_hcnt_max ? r_hcnt : r_hcnt + CW'(1);
   assign w_vcnt_inc = w_vcnt_max ? r_vcnt : r_vcnt + CW'(1);

   // Edges seen in the LS cycle itself still belong to the line being closed.
   assign w_hs_tot = {1'b0, r_hs_rise} + {2'b00, w_hs_rise};
   assign w_hb_tot = {1'b0, r_hb_rise} + {2'b00, w_hb_rise};
   assign w_vs_tot = {1'b0, r_vs_rise} + {2'b00, w_vs_rise};

   assign w_line_fail  = w_ls & r_seen_ls &
                         ((w_hs_tot != 3'd1) | (w_hb_tot != 3'd1) |
                          (r_ht_valid & (w_hcnt_inc != r_h_total)));
   assign w_frame_fail = w_fs & (r_state != S_IDLE) &
                         ((w_vs_tot != 3'd1) | (r_vt_valid & (w_vcnt_inc != r_v_total)));
   assign w_sat_fail   = (w_hcnt_max & ~w_ls) | (w_vcnt_max & w_ls & ~w_fs);
   assign w_fail       = w_line_fail | w_frame_fail | w_sat_fail;

   assign w_cnt_inc = (&r_lock_cnt) ? r_lock_cnt : r_lock_cnt + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_lock_cnt;
      if (w_fs && (r_state == S_IDLE)) begin
         w_state_nxt = S_HUNT;
      end else if (w_fail) begin
         w_cnt_nxt = '0;
         if (r_state == S_LOCK) w_state_nxt = S_HUNT;
      end else if (w_fs && !r_frame_bad) begin
         w_cnt_nxt = w_cnt_inc;
         if (w_cnt_inc >= LOCK_N) w_state_nxt = S_LOCK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hblnk_q     <= 1'b1;
         r_vblnk_q     <= 1'b1;
         r_hsync_q     <= 1'b0;
         r_vsync_q     <= 1'b0;
         r_hcnt        <= '0;
         r_vcnt        <= '0;
         r_pend_v      <= 1'b0;
         r_seen_ls     <= 1'b0;
         r_ht_valid    <= 1'b0;
         r_vt_valid    <= 1'b0;
         r_in_active   <= 1'b0;
         r_hs_rise     <= '0;
         r_hb_rise     <= '0;
         r_vs_rise     <= '0;
         r_frame_bad   <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_h_total     <= '0;
         r_h_active    <= '0;
         r_v_total     <= '0;
         r_v_active    <= '0;
         r_err         <= 1'b0;
      end else begin
         r_hblnk_q     <= hblnk;
         r_vblnk_q     <= vblnk;
         r_hsync_q     <= hsync;
         r_vsync_q     <= vsync;
         r_pixel_valid <= ~hblnk & ~vblnk;
         r_line_start  <= w_ls;
         r_frame_start <= w_fs;
         r_err         <= w_fail & (r_state == S_LOCK);
         r_hcnt        <= w_ls ? '0 : w_hcnt_inc;
         r_seen_ls     <= r_seen_ls | w_ls;

         if (w_fs)           r_vcnt <= '0;
         else if (w_ls)      r_vcnt <= w_vcnt_inc;

         if (w_fs)           r_pend_v <= 1'b0;
         else if (w_vb_fall) r_pend_v <= 1'b1;

         if (w_ls && r_seen_ls) begin
            r_h_total  <= w_hcnt_inc;
            r_ht_valid <= 1'b1;
         end
         if (w_hb_rise) r_h_active <= w_hcnt_inc;

         if (w_fs && (r_state != S_IDLE)) begin
            r_v_total  <= w_vcnt_inc;
            r_vt_valid <= 1'b1;
         end
         if (w_ls && !vblnk) begin
            r_in_active <= 1'b1;
         end else if (w_ls && r_in_active) begin
            r_v_active  <= w_vcnt_inc;
            r_in_active <= 1'b0;
         end

         if (w_ls) begin
            r_hs_rise <= '0;
            r_hb_rise <= '0;
         end else begin
            r_hs_rise <= (r_hs_rise == 2'd3) ? 2'd3 : r_hs_rise + {1'b0, w_hs_rise};
            r_hb_rise <= (r_hb_rise == 2'd3) ? 2'd3 : r_hb_rise + {1'b0, w_hb_rise};
         end
         if (w_fs) r_vs_rise <= '0;
         else      r_vs_rise <= (r_vs_rise == 2'd3) ? 2'd3 : r_vs_rise + {1'b0, w_vs_rise};

         // A violation found on the frame-start cycle belongs to the frame just closed.
         if (w_fs)        r_frame_bad <= 1'b0;
         else if (w_fail) r_frame_bad <= 1'b1;
      end
   end

   assign x           = r_hcnt;
   assign y           = r_vcnt;
   assign pixel_valid = r_pixel_valid;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign h_total     = r_h_total;
   assign h_active    = r_h_active;
   assign v_total     = r_v_total;
   assign v_active    = r_v_active;
   assign locked      = (r_state == S_LOCK);
   assign err         = r_err;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced raster (64x20 total,
// 48x16 active) so that multi-frame lock sequences stay short.
module tb_vga_timing_decoder;

   localparam int CW          = 11;
   localparam int LOCK_FRAMES = 2;
   localparam int H_TOTAL     = 64;
   localparam int H_BLANK     = 48;
   localparam int H_SS        = 52;
   localparam int H_SE        = 60;
   localparam int V_TOTAL     = 20;
   localparam int V_BLANK     = 16;
   localparam int V_SS        = 17;
   localparam int V_SE        = 19;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          hsync = 1'b0;
   logic          hblnk = 1'b1;
   logic          vsync = 1'b0;
   logic          vblnk = 1'b1;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          pixel_valid;
   logic          line_start;
   logic          frame_start;
   logic [CW-1:0] h_total;
   logic [CW-1:0] h_active;
   logic [CW-1:0] v_total;
   logic [CW-1:0] v_active;
   logic          locked;
   logic          err;

   vga_timing_decoder #(.CW(CW), .LOCK_FRAMES(LOCK_FRAMES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync      (hsync),
      .hblnk      (hblnk),
      .vsync      (vsync),
      .vblnk      (vblnk),
      .x          (x),
      .y          (y),
      .pixel_valid(pixel_valid),
      .line_start (line_start),
      .frame_start(frame_start),
      .h_total    (h_total),
      .h_active   (h_active),
      .v_total    (v_total),
      .v_active   (v_active),
      .locked     (locked),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          pv;
      logic          ls;
      logic          fs;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   errors     = 0;
   int   hc         = 0;
   int   vc         = 0;
   int   h_len      = H_TOTAL;
   int   err_cnt    = 0;
   int   dut_fs_cnt = 0;
   int   model_fs   = 0;
   bit   track      = 1'b0;
   bit   force_hb   = 1'b0;
   bit   kill_hs    = 1'b0;
   bit   early_v    = 1'b0;
   logic last_err   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One pixel: drive the source timing for (hc,vc), queue what x/y/flags must
   // read after the edge, then compare and advance the source counters.
   task automatic cyc();
      exp_t e;
      hblnk = (hc >= H_BLANK) || force_hb;
      hsync = (hc >= H_SS) && (hc < H_SE) && !kill_hs;
      vblnk = (vc >= V_BLANK) && !(early_v && (vc == V_TOTAL - 1) && (hc >= H_TOTAL - 5));
      vsync = (vc >= V_SS) && (vc < V_SE);
      if (hc == 0 && vc == 0) model_fs++;
      if (track) begin
         e.x  = CW'(hc);
         e.y  = CW'(vc);
         e.pv = (hc < H_BLANK) && (vc < V_BLANK);
         e.ls = (hc == 0);
         e.fs = (hc == 0) && (vc == 0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      last_err = err;
      err_cnt += int'(err);
      dut_fs_cnt += int'(frame_start);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("x", 32'(x), 32'(e.x));
         check("y", 32'(y), 32'(e.y));
         check("pixel_valid", 32'(pixel_valid), 32'(e.pv));
         check("line_start", 32'(line_start), 32'(e.ls));
         check("frame_start", 32'(frame_start), 32'(e.fs));
      end
      hc++;
      if (hc >= h_len) begin
         hc = 0;
         vc++;
         if (vc == V_TOTAL) vc = 0;
      end
   endtask

   task automatic run_until(input int th, input int tv);
      int n = 0;
      while (!(hc == th && vc == tv) && n < 4 * H_TOTAL * V_TOTAL) begin
         cyc();
         n++;
      end
   endtask

   task automatic run_frames(input int n);
      int target = model_fs + n;
      while (model_fs < target) cyc();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_x"}, 32'(x), 0);
      check({tag, "_y"}, 32'(y), 0);
      check({tag, "_pv"}, 32'(pixel_valid), 0);
      check({tag, "_ls"}, 32'(line_start), 0);
      check({tag, "_fs"}, 32'(frame_start), 0);
      check({tag, "_h_total"}, 32'(h_total), 0);
      check({tag, "_h_active"}, 32'(h_active), 0);
      check({tag, "_v_total"}, 32'(v_total), 0);
      check({tag, "_v_active"}, 32'(v_active), 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");

      // Acquire: frame start at release, geometry after the second, lock at the third.
      rst_n = 1'b1;
      track = 1'b1;
      run_frames(1);
      check("lock_after_fs1", 32'(locked), 0);
      run_frames(1);
      check("h_total", 32'(h_total), H_TOTAL);
      check("h_active", 32'(h_active), H_BLANK);
      check("v_total", 32'(v_total), V_TOTAL);
      check("v_active", 32'(v_active), V_BLANK);
      check("lock_after_fs2", 32'(locked), 0);
      run_frames(1);
      check("lock_after_fs3", 32'(locked), 1);
      check("no_err_acquire", 32'(err_cnt), 0);

      // One line stretched by a cycle.
      run_until(0, 5);
      h_len = H_TOTAL + 1;
      repeat (H_TOTAL + 1) cyc();
      h_len = H_TOTAL;
      cyc();
      check("stretch_err", 32'(last_err), 1);
      check("stretch_unlock", 32'(locked), 0);
      check("stretch_h_total", 32'(h_total), H_TOTAL + 1);
      repeat (H_TOTAL) cyc();
      check("stretch_next_err", 32'(last_err), 0);
      check("stretch_h_total_back", 32'(h_total), H_TOTAL);
      check("stretch_err_once", 32'(err_cnt), 1);
      run_frames(1);
      check("relock_bad_frame", 32'(locked), 0);
      run_frames(1);
      check("relock_clean1", 32'(locked), 0);
      run_frames(1);
      check("relock_clean2", 32'(locked), 1);

      // Missing hsync on one line.
      run_until(0, 3);
      kill_hs = 1'b1;
      repeat (H_TOTAL) cyc();
      kill_hs = 1'b0;
      cyc();
      check("nohs_err", 32'(last_err), 1);
      check("nohs_unlock", 32'(locked), 0);
      check("nohs_err_cnt", 32'(err_cnt), 2);

      // Blanking held high long enough to saturate the column counter.
      run_until(H_BLANK, 4);
      track    = 1'b0;
      force_hb = 1'b1;
      for (int i = 0; i < 2100; i++) begin
         cyc();
         check("sat_x", 32'(x), (H_BLANK + i > 2047) ? 2047 : H_BLANK + i);
         check("sat_locked", 32'(locked), 0);
      end
      force_hb = 1'b0;
      check("sat_no_err", 32'(err_cnt), 2);

      // Asynchronous reset in the middle of the active area.
      run_until(40, 10);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      run_until(40, V_SS);
      check("rst_hold_x", 32'(x), 0);
      rst_n      = 1'b1;
      dut_fs_cnt = 0;
      run_until(0, 0);
      check("rst_no_early_fs", 32'(dut_fs_cnt), 0);
      track = 1'b1;
      cyc();
      check("rst_fs", 32'(frame_start), 1);
      check("rst_y0", 32'(y), 0);
      check("rst_v_total_skip", 32'(v_total), 0);
      check("rst_locked", 32'(locked), 0);

      // vblnk falls five cycles ahead of hblnk at the frame boundary.
      early_v = 1'b1;
      run_frames(1);
      early_v = 1'b0;
      check("early_v_fs", 32'(frame_start), 1);
      check("early_v_ls", 32'(line_start), 1);
      check("early_v_y", 32'(y), 0);
      check("early_v_v_total", 32'(v_total), V_TOTAL);
      check("early_v_v_active", 32'(v_active), V_BLANK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
